// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver presenting an Apple-1 style KBD/KBDCR register pair.
// The serial device stream is conditioned and framed, and set-2 scan codes are
// translated to 7-bit uppercase ASCII. One character is held until the CPU reads it.
module ps2_keyboard #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 25000
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       enable,
  input  logic [1:0] address,
  input  logic       w_en,
  output logic [7:0] dout,
  output logic       kbd_ready
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, fall;
  rx_state_t     state, state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit, frame_valid, timeout_hit;
  logic [TW-1:0] to_cnt;
  logic          ext, brk, shift_l, shift_r, ctrl;
  logic          map_hit, is_letter, char_valid, read_clear;
  logic [6:0]    map_ascii, char_ascii, kbd_data;

  // Two-flop synchronisers for both PS/2 lines. The lines idle high.
  // NOTE: all state uses non-blocking assignments, so every flop samples the pre-edge values.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1; dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk; clk_s2 <= clk_s1;
      dat_s1 <= ps2_data; dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: the level follows the synced clock only after FILTER_LEN differing samples.
  // The falling edge of the filtered clock produces a one-cycle fall pulse.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      filt_cnt <= '0; filt_clk <= 1'b1; fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_cnt <= '0;
        filt_clk <= clk_s2;
        fall     <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign timeout_hit = (state != S_IDLE) && !fall && (to_cnt == TW'(TIMEOUT - 1));

  // Receive FSM state register.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Receive FSM next state. A stalled frame falls back to IDLE.
  // NOTE: defaults are assigned first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (timeout_hit) begin
      state_next = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!dat_s2) state_next = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Frame datapath: bit counter, LSB-first shifter, parity, inter-edge timeout, frame check.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0; shreg <= '0; par_bit <= 1'b0; to_cnt <= '0; frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (state == S_IDLE || fall) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          S_IDLE:   bit_cnt <= '0;
          S_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          S_PARITY: par_bit <= dat_s2;
          default:  frame_valid <= dat_s2 & (^{par_bit, shreg});
        endcase
      end
    end
  end

  // Scan-code lookup for the completed frame in shreg.
  always_comb begin
    map_hit   = 1'b1;
    is_letter = 1'b0;
    map_ascii = 7'h00;
    case (shreg)
      8'h1C: begin is_letter = 1'b1; map_ascii = 7'h41; end
      8'h32: begin is_letter = 1'b1; map_ascii = 7'h42; end
      8'h21: begin is_letter = 1'b1; map_ascii = 7'h43; end
      8'h23: begin is_letter = 1'b1; map_ascii = 7'h44; end
      8'h24: begin is_letter = 1'b1; map_ascii = 7'h45; end
      8'h2B: begin is_letter = 1'b1; map_ascii = 7'h46; end
      8'h34: begin is_letter = 1'b1; map_ascii = 7'h47; end
      8'h33: begin is_letter = 1'b1; map_ascii = 7'h48; end
      8'h43: begin is_letter = 1'b1; map_ascii = 7'h49; end
      8'h3B: begin is_letter = 1'b1; map_ascii = 7'h4A; end
      8'h42: begin is_letter = 1'b1; map_ascii = 7'h4B; end
      8'h4B: begin is_letter = 1'b1; map_ascii = 7'h4C; end
      8'h3A: begin is_letter = 1'b1; map_ascii = 7'h4D; end
      8'h31: begin is_letter = 1'b1; map_ascii = 7'h4E; end
      8'h44: begin is_letter = 1'b1; map_ascii = 7'h4F; end
      8'h4D: begin is_letter = 1'b1; map_ascii = 7'h50; end
      8'h15: begin is_letter = 1'b1; map_ascii = 7'h51; end
      8'h2D: begin is_letter = 1'b1; map_ascii = 7'h52; end
      8'h1B: begin is_letter = 1'b1; map_ascii = 7'h53; end
      8'h2C: begin is_letter = 1'b1; map_ascii = 7'h54; end
      8'h3C: begin is_letter = 1'b1; map_ascii = 7'h55; end
      8'h2A: begin is_letter = 1'b1; map_ascii = 7'h56; end
      8'h1D: begin is_letter = 1'b1; map_ascii = 7'h57; end
      8'h22: begin is_letter = 1'b1; map_ascii = 7'h58; end
      8'h35: begin is_letter = 1'b1; map_ascii = 7'h59; end
      8'h1A: begin is_letter = 1'b1; map_ascii = 7'h5A; end
      8'h45: map_ascii = (shift_l | shift_r) ? 7'h29 : 7'h30;
      8'h16: map_ascii = (shift_l | shift_r) ? 7'h21 : 7'h31;
      8'h1E: map_ascii = (shift_l | shift_r) ? 7'h40 : 7'h32;
      8'h26: map_ascii = (shift_l | shift_r) ? 7'h23 : 7'h33;
      8'h25: map_ascii = (shift_l | shift_r) ? 7'h24 : 7'h34;
      8'h2E: map_ascii = (shift_l | shift_r) ? 7'h25 : 7'h35;
      8'h36: map_ascii = (shift_l | shift_r) ? 7'h5E : 7'h36;
      8'h3D: map_ascii = (shift_l | shift_r) ? 7'h26 : 7'h37;
      8'h3E: map_ascii = (shift_l | shift_r) ? 7'h2A : 7'h38;
      8'h46: map_ascii = (shift_l | shift_r) ? 7'h28 : 7'h39;
      8'h29: map_ascii = 7'h20;
      8'h41: map_ascii = (shift_l | shift_r) ? 7'h3C : 7'h2C;
      8'h49: map_ascii = (shift_l | shift_r) ? 7'h3E : 7'h2E;
      8'h4A: map_ascii = (shift_l | shift_r) ? 7'h3F : 7'h2F;
      8'h4C: map_ascii = (shift_l | shift_r) ? 7'h3A : 7'h3B;
      8'h52: map_ascii = (shift_l | shift_r) ? 7'h22 : 7'h27;
      8'h4E: map_ascii = (shift_l | shift_r) ? 7'h5F : 7'h2D;
      8'h55: map_ascii = (shift_l | shift_r) ? 7'h2B : 7'h3D;
      8'h5A: map_ascii = 7'h0D;
      8'h66: map_ascii = 7'h5F;
      8'h76: map_ascii = 7'h1B;
      default: map_hit = 1'b0;
    endcase
  end

  assign char_ascii = (is_letter && ctrl) ? (map_ascii & 7'h1F) : map_ascii;
  assign char_valid = frame_valid && map_hit && !brk && !ext;
  assign read_clear = enable && !w_en && (address == 2'd0);

  // Prefix and modifier tracking. A prefix is held until the next non-prefix code.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      ext <= 1'b0; brk <= 1'b0; shift_l <= 1'b0; shift_r <= 1'b0; ctrl <= 1'b0;
    end else if (frame_valid) begin
      case (shreg)
        8'hE0: ext <= 1'b1;
        8'hF0: brk <= 1'b1;
        8'h12: begin shift_l <= ~brk; ext <= 1'b0; brk <= 1'b0; end
        8'h59: begin shift_r <= ~brk; ext <= 1'b0; brk <= 1'b0; end
        8'h14: begin ctrl    <= ~brk; ext <= 1'b0; brk <= 1'b0; end
        default: begin ext <= 1'b0; brk <= 1'b0; end
      endcase
    end
  end

  // Character latch. A new key loads only when the latch is empty or being read this cycle.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      kbd_ready <= 1'b0; kbd_data <= '0;
    end else if (char_valid && (!kbd_ready || read_clear)) begin
      kbd_ready <= 1'b1; kbd_data <= char_ascii;
    end else if (read_clear) begin
      kbd_ready <= 1'b0;
    end
  end

  // Register read mux into the CPU data bus.
  always_comb begin
    dout = 8'h00;
    case (address)
      2'd0:    dout = {1'b1, kbd_data};
      2'd1:    dout = {kbd_ready, 7'b0};
      default: dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: a table of scan-code frames with a
// queue of expected characters, plus hand-written timeout, overrun,
// read/load collision and mid-frame reset sequences.
module tb_ps2_keyboard;

  localparam int HALF = 10;   // PS/2 half bit period in clk25 cycles
  localparam int TMO  = 100;

  logic       clk25 = 1'b0;
  logic       reset, ps2_clk, ps2_data, enable, w_en;
  logic [1:0] address;
  logic [7:0] dout;
  logic       kbd_ready;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       has_char;
    logic [7:0] exp;
    string      name;
  } vec_t;
  vec_t vecs[$];

  ps2_keyboard #(.FILTER_LEN(4), .TIMEOUT(TMO)) u_dut (
    .clk25(clk25), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .enable(enable), .address(address), .w_en(w_en), .dout(dout), .kbd_ready(kbd_ready)
  );

  always #5 clk25 = ~clk25;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%02h required=0x%02h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk25);
  endtask

  // Drive the first nbits of an 11-bit frame (start, 8 data LSB first, parity, stop).
  task automatic send_bits(input logic [7:0] code, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk25);
    enable = 1'b0; address = a;
    #1 d = dout;
  endtask

  task automatic read_clear(output logic [7:0] d);
    @(negedge clk25);
    address = 2'd0; enable = 1'b1; w_en = 1'b0;
    #1 d = dout;
    @(negedge clk25);
    enable = 1'b0;
  endtask

  // Compare the latch against the scoreboard head, then read it out.
  task automatic consume(input string name);
    logic [7:0] d, e;
    wait_cycles(HALF);
    if (exp_q.size() == 0) begin
      check({name, "/idle_ready"}, {7'b0, kbd_ready}, 8'h00);
    end else begin
      e = exp_q.pop_front();
      check({name, "/ready"}, {7'b0, kbd_ready}, 8'h01);
      peek(2'd1, d);
      check({name, "/kbdcr"}, d, 8'h80);
      read_clear(d);
      check({name, "/kbd"}, d, e);
      @(negedge clk25);
      check({name, "/cleared"}, {7'b0, kbd_ready}, 8'h00);
      peek(2'd1, d);
      check({name, "/kbdcr_clr"}, d, 8'h00);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic found;

    vecs.push_back('{8'h1C, 1'b0, 1'b1, 8'hC1, "A"});
    vecs.push_back('{8'h12, 1'b0, 1'b0, 8'h00, "lshift_make"});
    vecs.push_back('{8'h16, 1'b0, 1'b1, 8'hA1, "bang"});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, "brk1"});
    vecs.push_back('{8'h16, 1'b0, 1'b0, 8'h00, "brk_1"});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, "brk2"});
    vecs.push_back('{8'h12, 1'b0, 1'b0, 8'h00, "lshift_brk"});
    vecs.push_back('{8'h16, 1'b0, 1'b1, 8'hB1, "one"});
    vecs.push_back('{8'h1C, 1'b1, 1'b0, 8'h00, "bad_parity"});
    vecs.push_back('{8'h32, 1'b0, 1'b1, 8'hC2, "B"});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 8'h00, "ext"});
    vecs.push_back('{8'h75, 1'b0, 1'b0, 8'h00, "arrow"});
    vecs.push_back('{8'h14, 1'b0, 1'b0, 8'h00, "ctrl_make"});
    vecs.push_back('{8'h21, 1'b0, 1'b1, 8'h83, "ctrl_C"});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, "brk3"});
    vecs.push_back('{8'h14, 1'b0, 1'b0, 8'h00, "ctrl_brk"});
    vecs.push_back('{8'h45, 1'b0, 1'b1, 8'hB0, "zero"});
    vecs.push_back('{8'h5A, 1'b0, 1'b1, 8'h8D, "enter"});
    vecs.push_back('{8'h66, 1'b0, 1'b1, 8'hDF, "rubout"});
    vecs.push_back('{8'h76, 1'b0, 1'b1, 8'h9B, "esc"});
    vecs.push_back('{8'h29, 1'b0, 1'b1, 8'hA0, "space"});
    vecs.push_back('{8'h4A, 1'b0, 1'b1, 8'hAF, "slash"});
    vecs.push_back('{8'h59, 1'b0, 1'b0, 8'h00, "rshift_make"});
    vecs.push_back('{8'h55, 1'b0, 1'b1, 8'hAB, "plus"});
    vecs.push_back('{8'h4C, 1'b0, 1'b1, 8'hBA, "colon"});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, "brk4"});
    vecs.push_back('{8'h59, 1'b0, 1'b0, 8'h00, "rshift_brk"});
    vecs.push_back('{8'h55, 1'b0, 1'b1, 8'hBD, "equals"});
    vecs.push_back('{8'h52, 1'b0, 1'b1, 8'hA7, "quote"});
    vecs.push_back('{8'h0E, 1'b0, 1'b0, 8'h00, "unmapped"});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 8'h00, "ext2"});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, "ext_brk"});
    vecs.push_back('{8'h1C, 1'b0, 1'b0, 8'h00, "ext_brk_A"});
    vecs.push_back('{8'h1C, 1'b0, 1'b1, 8'hC1, "A_after_prefix"});
    vecs.push_back('{8'h1A, 1'b0, 1'b1, 8'hDA, "Z"});

    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    enable = 1'b0; w_en = 1'b0; address = 2'd0;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);

    // Reset state of every register address.
    peek(2'd0, d); check("rst/addr0", d, 8'h80);
    peek(2'd1, d); check("rst/addr1", d, 8'h00);
    peek(2'd2, d); check("rst/addr2", d, 8'h00);
    peek(2'd3, d); check("rst/addr3", d, 8'h00);

    foreach (vecs[i]) begin
      if (vecs[i].has_char) exp_q.push_back(vecs[i].exp);
      send_bits(vecs[i].code, vecs[i].bad_par, 11);
      consume(vecs[i].name);
    end

    // Stalled partial frame is abandoned after the timeout.
    send_bits(8'h1C, 1'b0, 5);
    wait_cycles(2 * TMO);
    exp_q.push_back(8'h8D);
    send_bits(8'h5A, 1'b0, 11);
    consume("timeout_enter");

    // Unread character is kept when another key arrives.
    send_bits(8'h1C, 1'b0, 11);
    send_bits(8'h32, 1'b0, 11);
    wait_cycles(HALF);
    peek(2'd0, d); check("overrun/kept", d, 8'hC1);
    peek(2'd1, d); check("overrun/ready", d, 8'h80);

    // Read-clear coinciding with the frame_valid cycle of a new key.
    exp_q.push_back(8'hC1);
    found = 1'b0;
    fork
      send_bits(8'h21, 1'b0, 11);
      begin
        for (int i = 0; i < 2000 && !found; i++) begin
          @(posedge clk25);
          #1;
          if (u_dut.frame_valid) found = 1'b1;
        end
        if (found) begin
          address = 2'd0; enable = 1'b1; w_en = 1'b0;
          #1 check("collide/old", dout, exp_q.pop_front());
          @(posedge clk25);
          #1 enable = 1'b0;
        end else begin
          checks++; failures++;
          $display("FAIL collide/frame_wait: actual=no_frame required=frame_valid");
        end
      end
    join
    exp_q.push_back(8'hC3);
    consume("collide_C");

    // Writes do not clear; reset mid-frame leaves nothing behind.
    send_bits(8'h1C, 1'b0, 11);
    wait_cycles(HALF);
    @(negedge clk25);
    address = 2'd0; enable = 1'b1; w_en = 1'b1;
    @(negedge clk25);
    enable = 1'b0; w_en = 1'b0;
    check("write_ignored", {7'b0, kbd_ready}, 8'h01);
    send_bits(8'h32, 1'b0, 4);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(3);
    peek(2'd0, d); check("midrst/addr0", d, 8'h80);
    peek(2'd1, d); check("midrst/addr1", d, 8'h00);
    exp_q.push_back(8'hC1);
    send_bits(8'h1C, 1'b0, 11);
    consume("after_reset_A");

    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard receiver and Apple-1 keyboard port. It decodes the serial PS/2 device stream into 7-bit uppercase ASCII and presents it as the KBD/KBDCR register pair. The block feeds the CPU read-data mux: the top level chip-selects it on the keyboard address window and routes `dout` into `dbi` next to RAM, ROM and UART. Only make codes produce characters; break codes and unmapped keys are consumed silently.

## Interface
- `FILTER_LEN`, 4: number of consecutive equal `clk25` samples required before the filtered PS/2 clock changes level.
- `TIMEOUT`, 25000: `clk25` cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 25 MHz).
- `clk25  in  1`: system clock; all state is on the rising edge.
- `reset  in  1`: asynchronous, active-high; clears all state.
- `ps2_clk  in  1`: raw PS/2 clock, asynchronous.
- `ps2_data  in  1`: raw PS/2 data, asynchronous.
- `enable  in  1`: chip select qualified by `cpu_clken`; one-cycle access strobe.
- `address  in  2`: register select.
- `w_en  in  1`: write qualifier; writes are ignored.
- `dout  out  8`: read data, combinational from `address` and registers.
- `kbd_ready  out  1`: a character is waiting.

## Operation
- **Input conditioning**
  - Both PS/2 lines pass through 2-FF synchronisers.
  - The synced clock feeds a glitch filter: the filtered level changes after `FILTER_LEN` equal samples.
  - A falling edge of the filtered clock gives a one-cycle `fall` pulse.
  - The data line is sampled on `fall`.
- **Receive FSM**, states IDLE, DATA, PARITY, STOP:
  - IDLE: on `fall` with data=0 (start bit), go to DATA with bit count 0. On `fall` with data=1, stay in IDLE.
  - DATA: shift data in LSB first; after the 8th bit go to PARITY.
  - PARITY: latch the parity bit; go to STOP.
  - STOP: on `fall`, if stop=1 and the 9 bits have odd parity, raise `frame_valid` for one cycle with `code[7:0]`. Go to IDLE either way; a bad frame is dropped.
  - In any state except IDLE, a timeout counter reloads on every `fall`. Reaching `TIMEOUT` returns the FSM to IDLE and discards the partial frame.
- **Decoder** (acts on `frame_valid`):
  - 0xE0 sets `ext`. 0xF0 sets `brk`. Both are kept until the next non-prefix code, then cleared.
  - 0x12 and 0x59 update `shift_l` and `shift_r` (cleared if `brk`); 0x14 updates `ctrl`. `ext` is ignored for modifiers.
  - Any other code with `brk` set: no output.
  - Any other code with `ext` set: no output.
  - Letters 0x1C,0x32,0x21,…,0x1A map to 'A'..'Z' (always uppercase). With `ctrl`, the value is ASCII & 0x1F.
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to '0'..'9'. With shift they map to ")!@#$%^&*(".
  - Punctuation unshifted/shifted: 0x29 space, 0x41 ',' '<', 0x49 '.' '>', 0x4A '/' '?', 0x4C ';' ':', 0x52 ''' '"', 0x4E '-' '_', 0x55 '=' '+'.
  - 0x5A maps to 0x0D, 0x66 to 0x5F (Apple-1 rubout), 0x76 to 0x1B.
  - Unmapped codes produce no output.
- **Character latch**
  - A mapped key loads `kbd_data[6:0]` and sets `kbd_ready`, but only if `kbd_ready` is 0. Otherwise the character is dropped and the latch is kept.
  - A read with `enable` & !`w_en` & `address`=0 clears `kbd_ready`.
  - If a clear and a new character occur in the same cycle, the new character loads and `kbd_ready` stays 1.
- **Register map** (`dout`):
  - 0 reads {1, `kbd_data`}.
  - 1 reads {`kbd_ready`, 7'b0}.
  - 2 and 3 read 0x00.

## Timing
- Reset values:
  - FSM in IDLE.
  - `kbd_ready`=0, `kbd_data`=0.
  - `ext`, `brk` and all modifier flags 0.
  - Filtered clock 1; synchronisers 1.
  - `dout` therefore reads 0x80 at address 0 and 0x00 at address 1.
- The filtered clock edge lags the raw line by 2 cycles (synchroniser) plus `FILTER_LEN` cycles (filter).
- `frame_valid` is asserted in the cycle after the `fall` that samples the stop bit.
- `kbd_ready` and `kbd_data` update on the clock edge that ends the `frame_valid` cycle, so they are visible 2 cycles after the stop-bit `fall`.
- The read-clear takes effect on the edge ending the `enable` cycle. `dout` during that cycle still shows the old value.
- A reset in mid-frame aborts the frame; no partial state survives.

## Test plan
- Frame 0x1C (good parity, 60 µs bit period) → `kbd_ready`=1; address 0 reads 0xC1; address 1 reads 0x80. A read at address 0 then clears ready, and address 1 reads 0x00.
- Sequence 0x12, 0x16, 0xF0, 0x16, 0xF0, 0x12, 0x16 → first character 0xA1 ('!'). After reading it, the next character is 0xB1 ('1').
- Frame 0x1C with the parity bit inverted → `kbd_ready` stays 0, and the next good 0x32 frame yields 0xC2.
- 5 bits of a frame followed by a 2×`TIMEOUT` pause, then a full 0x5A frame → exactly one character, 0x8D.
- Unread 'A', then frame 0x32 → address 0 still reads 0xC1. Then a read-clear issued in the same cycle that the 0x21 frame completes → address 0 reads 0xC3 and `kbd_ready`=1.
- Frames 0xE0, 0x75, then 0x14, 0x21 → the arrow key produces nothing; Ctrl+C gives 0x83.
